inv_sbox_layer_seq: RTL and testbench

//  Inverse of the ASCON substitution layer on the 320-bit state (x0..x4, 64 columns).

---
 rtl/inv_sbox_layer_seq.sv | 114 +++++++++++
 tb/tb_inv_sbox_layer_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_layer_seq.sv
// Inverse ASCON substitution layer over the 320-bit state, processing
// COLS_PER_CYCLE columns per clock behind a start/done handshake.
module inv_sbox_layer_seq #(
  parameter int unsigned COLS_PER_CYCLE = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [319:0] state_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [6:0] STEP = 7'(COLS_PER_CYCLE);
  localparam logic [5:0] LAST = 6'(7'd64 - STEP);

  fsm_t         fsm_q;
  logic [5:0]   col_q;
  logic [319:0] sub_d;
  logic [63:0]  lane [5];
  logic [5:0]   j;
  logic [4:0]   colv;
  logic [4:0]   subv;

  function automatic logic [4:0] inv_sbox(input logic [4:0] v);
    case (v)
      5'h00: inv_sbox = 5'h14;  5'h01: inv_sbox = 5'h1A;
      5'h02: inv_sbox = 5'h07;  5'h03: inv_sbox = 5'h0D;
      5'h04: inv_sbox = 5'h00;  5'h05: inv_sbox = 5'h09;
      5'h06: inv_sbox = 5'h0E;  5'h07: inv_sbox = 5'h12;
      5'h08: inv_sbox = 5'h0A;  5'h09: inv_sbox = 5'h06;
      5'h0A: inv_sbox = 5'h1D;  5'h0B: inv_sbox = 5'h01;
      5'h0C: inv_sbox = 5'h19;  5'h0D: inv_sbox = 5'h15;
      5'h0E: inv_sbox = 5'h13;  5'h0F: inv_sbox = 5'h1E;
      5'h10: inv_sbox = 5'h18;  5'h11: inv_sbox = 5'h16;
      5'h12: inv_sbox = 5'h0B;  5'h13: inv_sbox = 5'h11;
      5'h14: inv_sbox = 5'h03;  5'h15: inv_sbox = 5'h05;
      5'h16: inv_sbox = 5'h1C;  5'h17: inv_sbox = 5'h1F;
      5'h18: inv_sbox = 5'h17;  5'h19: inv_sbox = 5'h1B;
      5'h1A: inv_sbox = 5'h04;  5'h1B: inv_sbox = 5'h08;
      5'h1C: inv_sbox = 5'h0F;  5'h1D: inv_sbox = 5'h0C;
      5'h1E: inv_sbox = 5'h10;
      default: inv_sbox = 5'h02;
    endcase
  endfunction

  // Split into x0..x4 lanes so each column is addressed by a 6-bit index.
  always_comb begin
    for (int unsigned k = 0; k < 5; k++) lane[k] = state_o[64*(4-k) +: 64];
    j    = '0;
    colv = '0;
    subv = '0;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      j    = col_q + 6'(i);
      colv = {lane[0][j], lane[1][j], lane[2][j], lane[3][j], lane[4][j]};
      subv = inv_sbox(colv);
      for (int unsigned k = 0; k < 5; k++) lane[k][j] = subv[4-k];
    end
    sub_d = {lane[0], lane[1], lane[2], lane[3], lane[4]};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      col_q   <= '0;
      state_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_o <= state_i;
            col_q   <= '0;
            busy_o  <= 1'b1;
            fsm_q   <= BUSY;
          end else begin
            busy_o <= 1'b0;
          end
        end
        BUSY: begin
          state_o <= sub_d;
          col_q   <= col_q + STEP[5:0];
          if (col_q == LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            fsm_q  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_o <= state_i;
            col_q   <= '0;
            busy_o  <= 1'b1;
            fsm_q   <= BUSY;
          end else begin
            fsm_q <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          fsm_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbox_layer_seq.sv
// Self-checking bench: three instances (1, 4 and 64 columns per cycle) checked
// against a column-wise table model using the ASCON forward and inverse S-boxes.
module tb_inv_sbox_layer_seq;

  localparam logic [4:0] INV [32] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02};
  localparam logic [4:0] FWD [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  logic         clk = 1'b0;
  logic         rst;
  logic         start [3];
  logic [319:0] sin   [3];
  logic         busy  [3];
  logic         done  [3];
  logic [319:0] sout  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inv_sbox_layer_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]), .state_i(sin[0]),
    .busy_o(busy[0]), .done_o(done[0]), .state_o(sout[0]));
  inv_sbox_layer_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]), .state_i(sin[1]),
    .busy_o(busy[1]), .done_o(done[1]), .state_o(sout[1]));
  inv_sbox_layer_seq #(.COLS_PER_CYCLE(64)) dut64 (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]), .state_i(sin[2]),
    .busy_o(busy[2]), .done_o(done[2]), .state_o(sout[2]));

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Column j is the 5-bit word {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 in bits 319:256.
  function automatic logic [319:0] layer(input logic [319:0] s, input bit inverse);
    logic [319:0] r;
    logic [4:0] v, w;
    r = s;
    for (int c = 0; c < 64; c++) begin
      for (int b = 0; b < 5; b++) v[4-b] = s[64*(4-b) + c];
      w = inverse ? INV[v] : FWD[v];
      for (int b = 0; b < 5; b++) r[64*(4-b) + c] = w[4-b];
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
    return s;
  endfunction

  task automatic run(input int d, input logic [319:0] s, output logic [319:0] r, output int cyc);
    sin[d]   = s;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cyc = 0;
    while (!done[d] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = sout[d];
  endtask

  logic [319:0] a, b, s, r, cap;
  int cyc, pulses;
  int cols [3] = '{1, 4, 64};
  int runs [3] = '{300, 1000, 1000};

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      sin[d]   = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_state_c%0d", cols[d]), sout[d], '0);
      check($sformatf("reset_busy_c%0d", cols[d]), 320'(busy[d]), '0);
      check($sformatf("reset_done_c%0d", cols[d]), 320'(done[d]), '0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Uniform-column table sweep.
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      s = '0;
      for (int bb = 0; bb < 5; bb++) s[64*(4-bb) +: 64] = {64{vv[4-bb]}};
      run(1, s, r, cyc);
      check($sformatf("table_v%02h", v), r, layer(s, 1'b1));
    end

    // Round trip through the forward layer for every width.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < runs[d]; n++) begin
        s = rand_state();
        run(d, layer(s, 1'b0), r, cyc);
        check($sformatf("roundtrip_c%0d", cols[d]), r, s);
        if (n == 0) check($sformatf("latency_c%0d", cols[d]), 320'(cyc), 320'(64 / cols[d]));
      end
      @(posedge clk); #1;
    end

    // Cycle-accurate busy/done profile for four columns per cycle.
    repeat (2) @(posedge clk);
    #1;
    a = rand_state();
    sin[1] = a; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      check($sformatf("lat_busy_%0d", i), 320'(busy[1]), 320'(1));
      check($sformatf("lat_nodone_%0d", i), 320'(done[1]), 320'(0));
    end
    @(posedge clk); #1;
    check("lat_done", 320'(done[1]), 320'(1));
    check("lat_busy_low", 320'(busy[1]), 320'(0));
    check("lat_result", sout[1], layer(a, 1'b1));
    @(posedge clk); #1;
    check("lat_done_once", 320'(done[1]), 320'(0));

    // A start pulse with a different state in mid-operation is ignored.
    a = rand_state();
    b = rand_state();
    sin[1] = a; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sin[1] = b; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    pulses = 0;
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      if (done[1]) begin pulses++; cap = sout[1]; end
      @(posedge clk); #1;
    end
    check("busy_start_pulses", 320'(pulses), 320'(1));
    check("busy_start_result", cap, layer(a, 1'b1));

    // Back-to-back: next start accepted in the DONE cycle.
    a = rand_state();
    b = rand_state();
    run(1, a, r, cyc);
    check("b2b_a_done", 320'(done[1]), 320'(1));
    check("b2b_a_result", r, layer(a, 1'b1));
    run(1, b, r, cyc);
    check("b2b_b_gap", 320'(cyc + 1), 320'(17));
    check("b2b_b_result", r, layer(b, 1'b1));
    @(posedge clk); #1;

    // Reset halfway through (column counter at 32) discards the work.
    a = rand_state();
    sin[1] = a; start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 320'(busy[1]), 320'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_state", sout[1], '0);
    check("mid_reset_busy", 320'(busy[1]), 320'(0));
    check("mid_reset_done", 320'(done[1]), 320'(0));
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done[1] || busy[1]) pulses++;
    end
    check("mid_reset_quiet", 320'(pulses), 320'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
